pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard/stall controller for a 5-stage MIPS pipeline with an
//               MDU busy tracker and multi-cycle branch flush window.
//               Optional perf counters via HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MDU_LAT  = 4,
    parameter int BR_FLUSH = 1,
    parameter int RAW      = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           id_uses_rs,
    input  logic           id_uses_rt,
    input  logic           id_is_mdu,
    input  logic           id_mdu_rd,
    input  logic           ex_memread,
    input  logic [RAW-1:0] ex_rd,
    input  logic           br_taken,
    output logic           pc_en,
    output logic           ifid_en,
    output logic           ifid_flush,
    output logic           idex_flush,
    output logic           mdu_busy,
    output logic           stall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    flush_cnt_o
`endif
);

    localparam logic [3:0] c_mdu_lat   = 4'(MDU_LAT);
    localparam logic [1:0] c_br_reload = 2'(BR_FLUSH - 1);

    logic [3:0] r_mdu_cnt;
    logic [1:0] r_flush_cnt;

    logic w_lu_haz;
    logic w_mdu_haz;
    logic w_flush;
    logic w_hazard;
    logic w_issue;

    assign mdu_busy  = (r_mdu_cnt != 4'd0);
    assign w_lu_haz  = ex_memread && (ex_rd != '0) &&
                       ((id_uses_rs && (id_rs == ex_rd)) ||
                        (id_uses_rt && (id_rt == ex_rd)));
    assign w_mdu_haz = mdu_busy && (id_is_mdu || id_mdu_rd);
    assign w_flush   = br_taken || (r_flush_cnt != 2'd0);
    assign w_hazard  = w_lu_haz || w_mdu_haz;
    // A killed or stalled MDU op must not start the latency counter.
    assign w_issue   = id_is_mdu && !w_flush && !w_hazard;

    // Reset forces idle outputs even while hazard-looking inputs are present.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall      = 1'b0;
        if (!rst) begin
            if (w_flush) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_hazard) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                stall      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= 2'd0;
        end else if (br_taken) begin
            r_flush_cnt <= c_br_reload;
        end else if (r_flush_cnt != 2'd0) begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdu_cnt <= 4'd0;
        end else if (w_issue) begin
            r_mdu_cnt <= c_mdu_lat;
        end else if (r_mdu_cnt != 4'd0) begin
            r_mdu_cnt <= r_mdu_cnt - 4'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ifid_flush) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Directed self-checking bench for pipe_hazard_ctrl (MDU_LAT=4, BR_FLUSH=2).
module tb_pipe_hazard_ctrl;

    localparam int MDU_LAT  = 4;
    localparam int BR_FLUSH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, id_is_mdu = 0, id_mdu_rd = 0;
    logic       ex_memread = 0, br_taken = 0;
    logic       pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .BR_FLUSH(BR_FLUSH), .RAW(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_mdu(id_is_mdu), .id_mdu_rd(id_mdu_rd),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .br_taken(br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .mdu_busy(mdu_busy), .stall(stall)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_is_mdu = 0; id_mdu_rd = 0;
        ex_memread = 0; br_taken = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        #1;
        total++;
        if ({pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, stall} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=110000",
                     {pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, stall});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        ex_memread = 1; ex_rd = 5'd8; id_uses_rs = 1; id_rs = 5'd8;
        #1;
        total++;
        if ({pc_en, ifid_en, ifid_flush, idex_flush, stall} !== 5'b00011) begin
            bad++;
            $display("FAIL load_use_rs got=%b want=00011",
                     {pc_en, ifid_en, ifid_flush, idex_flush, stall});
        end
        step(); idle(); #1;
        total++;
        if ({pc_en, ifid_en, idex_flush, stall} !== 4'b1100) begin
            bad++;
            $display("FAIL load_use_release got=%b want=1100",
                     {pc_en, ifid_en, idex_flush, stall});
        end
        ex_memread = 1; ex_rd = 5'd0; id_uses_rs = 1; id_rs = 5'd0;
        #1;
        total++;
        if (stall !== 1'b0 || pc_en !== 1'b1) begin
            bad++;
            $display("FAIL load_use_r0 stall=%b pc_en=%b want stall=0 pc_en=1", stall, pc_en);
        end
        step(); idle();
        ex_memread = 1; ex_rd = 5'd9; id_uses_rt = 1; id_rt = 5'd9; id_rs = 5'd9;
        #1;
        total++;
        if (stall !== 1'b1 || idex_flush !== 1'b1) begin
            bad++;
            $display("FAIL load_use_rt stall=%b idex_flush=%b want 1 1", stall, idex_flush);
        end
        id_uses_rt = 0; id_uses_rs = 0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_unused stall=%b want 0", stall);
        end
        ex_memread = 0; id_uses_rt = 1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_not_load stall=%b want 0", stall);
        end
        step(); idle();
    endtask

    task automatic test_mdu();
        id_is_mdu = 1;
        #1;
        total++;
        if (stall !== 1'b0 || mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL mdu_issue stall=%b busy=%b want 0 0", stall, mdu_busy);
        end
        step(); idle();
        id_mdu_rd = 1;
        for (int c = 1; c <= MDU_LAT; c++) begin
            #1;
            total++;
            if (stall !== 1'b1 || mdu_busy !== 1'b1 || pc_en !== 1'b0) begin
                bad++;
                $display("FAIL mdu_wait cyc=%0d stall=%b busy=%b pc_en=%b want 1 1 0",
                         c, stall, mdu_busy, pc_en);
            end
            step();
        end
        #1;
        total++;
        if (stall !== 1'b0 || mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL mdu_done stall=%b busy=%b want 0 0", stall, mdu_busy);
        end
        step(); idle();
    endtask

    task automatic test_mdu_boundary();
        id_is_mdu = 1;
        step(); idle();
        step(); step(); step();     // counter now at 1
        id_is_mdu = 1;
        #1;
        total++;
        if (stall !== 1'b1 || mdu_busy !== 1'b1) begin
            bad++;
            $display("FAIL mdu_cnt1_stall stall=%b busy=%b want 1 1", stall, mdu_busy);
        end
        step(); #1;
        total++;
        if (stall !== 1'b0 || mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL mdu_reissue stall=%b busy=%b want 0 0", stall, mdu_busy);
        end
        step(); idle(); #1;
        total++;
        if (mdu_busy !== 1'b1) begin
            bad++;
            $display("FAIL mdu_reloaded busy=%b want 1", mdu_busy);
        end
        // load-use and MDU hazard together: one stall, then re-evaluated
        id_mdu_rd = 1; ex_memread = 1; ex_rd = 5'd4; id_uses_rs = 1; id_rs = 5'd4;
        #1;
        total++;
        if (stall !== 1'b1 || idex_flush !== 1'b1 || ifid_flush !== 1'b0) begin
            bad++;
            $display("FAIL combo_haz stall=%b idex=%b ifid=%b want 1 1 0",
                     stall, idex_flush, ifid_flush);
        end
        step(); ex_memread = 0; #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL combo_reeval stall=%b want 1", stall);
        end
        idle();
        step(); step(); step(); #1;
        total++;
        if (mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL mdu_drain busy=%b want 0", mdu_busy);
        end
        step();
    endtask

    task automatic test_branch();
        ex_memread = 1; ex_rd = 5'd8; id_uses_rs = 1; id_rs = 5'd8; br_taken = 1;
        for (int c = 0; c < BR_FLUSH; c++) begin
            #1;
            total++;
            if ({pc_en, ifid_en, ifid_flush, idex_flush, stall} !== 5'b11110) begin
                bad++;
                $display("FAIL branch_flush cyc=%0d got=%b want=11110", c,
                         {pc_en, ifid_en, ifid_flush, idex_flush, stall});
            end
            step();
            br_taken = 0;
        end
        #1;
        total++;
        if (stall !== 1'b1 || ifid_flush !== 1'b0) begin
            bad++;
            $display("FAIL branch_after stall=%b ifid_flush=%b want 1 0", stall, ifid_flush);
        end
        step(); idle();
    endtask

    task automatic test_killed_mdu();
        id_is_mdu = 1; br_taken = 1;
        step(); idle(); #1;
        total++;
        if (mdu_busy !== 1'b0 || ifid_flush !== 1'b1) begin
            bad++;
            $display("FAIL killed_mdu busy=%b ifid_flush=%b want 0 1", mdu_busy, ifid_flush);
        end
        step(); step();
    endtask

    task automatic test_back_to_back();
        br_taken = 1;
        step();                 // second pulse reloads the window
        step(); br_taken = 0; #1;
        total++;
        if (ifid_flush !== 1'b1) begin
            bad++;
            $display("FAIL b2b_window ifid_flush=%b want 1", ifid_flush);
        end
        step(); #1;
        total++;
        if (ifid_flush !== 1'b0 || idex_flush !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end ifid=%b idex=%b want 0 0", ifid_flush, idex_flush);
        end
        idle();
    endtask

    task automatic test_async_reset();
        id_is_mdu = 1;
        step(); idle();
        step();                 // counter now at 3
        id_mdu_rd = 1;
        #1;
        total++;
        if (stall !== 1'b1 || mdu_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset stall=%b busy=%b want 1 1", stall, mdu_busy);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0 || mdu_busy !== 1'b0 || pc_en !== 1'b1) begin
            bad++;
            $display("FAIL async_reset stall=%b busy=%b pc_en=%b want 0 0 1",
                     stall, mdu_busy, pc_en);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset stall=%b busy=%b want 0 0", stall, mdu_busy);
        end
        idle();
        step();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1; step(); rst = 1'b0; idle(); step();
        for (int i = 0; i < 3; i++) begin
            ex_memread = 1; ex_rd = 5'd3; id_uses_rt = 1; id_rt = 5'd3;
            step(); idle(); step();
        end
        br_taken = 1;
        step(); br_taken = 0;
        step(); step(); #1;
        total++;
        if (stall_cnt !== 32'd3 || flush_cnt_o !== 32'(BR_FLUSH)) begin
            bad++;
            $display("FAIL perf_counts stall_cnt=%0d flush_cnt_o=%0d want 3 %0d",
                     stall_cnt, flush_cnt_o, BR_FLUSH);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_mdu();
        test_mdu_boundary();
        test_branch();
        test_killed_mdu();
        test_back_to_back();
        test_async_reset();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
